if_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the RV32I core. Owns the program counter and decides the next
//  PC: sequential, branch/jump redirect, trap vector or mret return. Drives the

---
 rtl/if_pkg.sv | 15 +
 rtl/if_npc_sel.sv | 38 +++
 rtl/if_fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch sequencer.
package if_pkg;

   localparam int          PC_W       = 32;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC priority mux (trap > mret > redirect > pc+4) with target alignment.
// Build option IF_TRAP_EN: misaligned mret/redirect targets divert to mtvec.
module if_npc_sel
   import if_pkg::*;
(
   input  logic            trap,
   input  logic [PC_W-1:0] mtvec,
   input  logic            mret,
   input  logic [PC_W-1:0] mepc,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] npc,
   output logic            misalign
);

   logic [PC_W-1:0] tgt;

   always_comb begin
      tgt      = pc + 32'd4;
      misalign = 1'b0;
      if (trap)
         tgt = mtvec;
      else if (mret)
         tgt = mepc;
      else if (redirect_valid)
         tgt = redirect_pc;
`ifdef IF_TRAP_EN
      // mtvec itself is never checked; only software-supplied targets can fault
      if (!trap && (mret || redirect_valid) && (tgt[1:0] != 2'b00)) begin
         misalign = 1'b1;
         tgt      = mtvec;
      end
`endif
      npc = tgt & ALIGN_MASK;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// RV32I fetch sequencer: owns the PC, runs the imem req/gnt/rvalid handshake and
// hands one instruction at a time to decode. Build option IF_TRAP_EN (see if_npc_sel).
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        trap,
   input  logic [31:0] mtvec,
   input  logic        mret,
   input  logic [31:0] mepc,
   output logic        fetch_misalign,
   output logic        fetch_timeout
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   fetch_state_t    state, state_d;
   logic [PC_W-1:0] pc, pc_d, npc;
   logic            kill, kill_d;
   logic            flush, misalign, capture;
   logic [CNT_W-1:0] wait_cnt;

   if_npc_sel u_npc_sel (
      .trap           (trap),
      .mtvec          (mtvec),
      .mret           (mret),
      .mepc           (mepc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .npc            (npc),
      .misalign       (misalign)
   );

   assign flush      = trap | mret | redirect_valid;
   assign imem_req   = (state == REQ);
   assign imem_addr  = pc;
   assign inst_valid = (state == HOLD);
   assign capture    = (state == WAIT) && imem_rvalid && !kill && !flush;

   always_comb begin
      state_d = state;
      kill_d  = kill;
      pc_d    = pc;
      if (flush)
         pc_d = npc;
      case (state)
         IDLE: state_d = REQ;
         REQ: begin
            // a redirect racing the grant leaves a response in flight that must be dropped
            if (imem_gnt) begin
               state_d = WAIT;
               kill_d  = flush;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = (kill || flush) ? REQ : HOLD;
               kill_d  = 1'b0;
            end else if (flush) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               state_d = REQ;
            end else if (inst_ready) begin
               state_d = REQ;
               pc_d    = npc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         kill  <= kill_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst    <= NOP_INST;
         inst_pc <= '0;
      end else if (capture) begin
         inst    <= imem_rdata;
         inst_pc <= pc;
      end
   end

   // wait counter saturates so the timeout fires once per stuck response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt       <= '0;
         fetch_timeout  <= 1'b0;
         fetch_misalign <= 1'b0;
      end else begin
         if ((state == WAIT) && !imem_rvalid) begin
            if (wait_cnt != CNT_W'(MAX_WAIT))
               wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         fetch_timeout  <= (state == WAIT) && !imem_rvalid &&
                           (wait_cnt == CNT_W'(MAX_WAIT - 1));
         fetch_misalign <= flush & misalign;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: vector table, directed corner sequences, then
// randomized traffic against a request/response-level reference model.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          MAX_WAIT = 8;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk, rst_n;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid, trap, mret;
   logic [31:0] redirect_pc, mtvec, mepc;
   logic        fetch_misalign, fetch_timeout;

   int n_chk  = 0;
   int n_pass = 0;

   if_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap           (trap),
      .mtvec          (mtvec),
      .mret           (mret),
      .mepc           (mepc),
      .fetch_misalign (fetch_misalign),
      .fetch_timeout  (fetch_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gnt, rvalid, ready;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_in();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; trap = 1'b0; mret = 1'b0; mepc = '0;
   endtask

   // From REQ at address a: grant, return word w one cycle later, check the held instruction.
   task automatic fetch_one(input logic [31:0] a, input logic [31:0] w, input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd1);
      chk({tag, "_addr"}, imem_addr, a);
      imem_gnt = 1'b1; step(); clr_in();
      chk({tag, "_noreq_wait"}, 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = w; step(); clr_in();
      chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
      chk({tag, "_inst_pc"}, inst_pc, a);
      chk({tag, "_inst"}, inst, w);
   endtask

   // Reference target selection computed directly from the priority/alignment rules.
   function automatic logic [32:0] tgt_of(input logic t, input logic m, input logic [31:0] mtv,
                                           input logic [31:0] mep, input logic [31:0] rp);
      logic [31:0] x;
      logic        mis;
      mis = 1'b0;
      if (t) x = mtv;
      else if (m) x = mep;
      else x = rp;
`ifdef IF_TRAP_EN
      if (!t && (x % 4) != 0) begin
         mis = 1'b1;
         x   = mtv;
      end
`endif
      x = x - (x % 4);
      return {mis, x};
   endfunction

   vec_t tbl[23];

   initial begin
      logic [31:0] exp_mis_addr;
      logic        m_started, m_pending, m_stale, m_held, m_to, m_mis;
      logic [31:0] m_pc, m_word, m_wpc;
      int          m_wait;

      tbl[0]  = '{0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0};
      tbl[1]  = '{0, 0, 0, 32'h0,         1, 32'h0,  0, 32'h0, 32'h0};
      tbl[2]  = '{1, 0, 0, 32'h0,         1, 32'h0,  0, 32'h0, 32'h0};
      tbl[3]  = '{0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0};
      tbl[4]  = '{0, 1, 0, 32'h00A0_0093, 0, 32'h0,  0, 32'h0, 32'h0};
      tbl[5]  = '{0, 0, 1, 32'h0,         0, 32'h0,  1, 32'h0, 32'h00A0_0093};
      tbl[6]  = '{0, 0, 0, 32'h0,         1, 32'h4,  0, 32'h0, 32'h0};
      tbl[7]  = '{1, 0, 0, 32'h0,         1, 32'h4,  0, 32'h0, 32'h0};
      tbl[8]  = '{0, 0, 0, 32'h0,         0, 32'h0,  0, 32'h0, 32'h0};
      tbl[9]  = '{0, 1, 0, 32'h00B0_0113, 0, 32'h0,  0, 32'h0, 32'h0};
      for (int i = 10; i < 15; i++)
         tbl[i] = '{0, 0, 0, 32'h0,       0, 32'h0,  1, 32'h4, 32'h00B0_0113};
      tbl[15] = '{0, 0, 1, 32'h0,         0, 32'h0,  1, 32'h4, 32'h00B0_0113};
      tbl[16] = '{1, 0, 0, 32'h0,         1, 32'h8,  0, 32'h0, 32'h0};
      tbl[17] = '{0, 1, 0, 32'h00C0_0193, 0, 32'h0,  0, 32'h0, 32'h0};
      tbl[18] = '{0, 0, 1, 32'h0,         0, 32'h0,  1, 32'h8, 32'h00C0_0193};
      tbl[19] = '{1, 0, 0, 32'h0,         1, 32'hC,  0, 32'h0, 32'h0};
      tbl[20] = '{0, 1, 0, 32'h00D0_0213, 0, 32'h0,  0, 32'h0, 32'h0};
      tbl[21] = '{0, 0, 1, 32'h0,         0, 32'h0,  1, 32'hC, 32'h00D0_0213};
      tbl[22] = '{0, 0, 0, 32'h0,         1, 32'h10, 0, 32'h0, 32'h0};

      rst_n = 1'b0; mtvec = 32'h80; clr_in();
      @(negedge clk); @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, NOP);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_timeout", 32'(fetch_timeout), 32'd0);
      chk("rst_misalign", 32'(fetch_misalign), 32'd0);
      rst_n = 1'b1;

      // sequential fetch, latency and decode stall
      for (int i = 0; i < 23; i++) begin
         chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
         if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_inst", i), inst, tbl[i].exp_inst);
         end
         imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid;
         imem_rdata = tbl[i].rdata; inst_ready = tbl[i].ready;
         step(); clr_in();
      end

      // redirect while waiting: stale word dropped, refetch at target
      imem_gnt = 1'b1; step(); clr_in();
      redirect_valid = 1'b1; redirect_pc = 32'h100; step(); clr_in();
      chk("rdw_noreq", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); clr_in();
      chk("rdw_drop_valid", 32'(inst_valid), 32'd0);
      fetch_one(32'h100, 32'h1111_0013, "rdw");

      // trap beats redirect
      trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; step(); clr_in();
      chk("trap_valid", 32'(inst_valid), 32'd0);
      fetch_one(32'h80, 32'h2222_0013, "trap");

      // redirect and ready together: redirect wins
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; step(); clr_in();
      chk("rdy_rd_req", 32'(imem_req), 32'd1);
      chk("rdy_rd_addr", imem_addr, 32'h40);

      // misaligned redirect while requesting
`ifdef IF_TRAP_EN
      exp_mis_addr = 32'h80;
`else
      exp_mis_addr = 32'h100;
`endif
      redirect_valid = 1'b1; redirect_pc = 32'h102; step(); clr_in();
`ifdef IF_TRAP_EN
      chk("mis_pulse", 32'(fetch_misalign), 32'd1);
`else
      chk("mis_pulse", 32'(fetch_misalign), 32'd0);
`endif
      chk("mis_req", 32'(imem_req), 32'd1);
      chk("mis_addr", imem_addr, exp_mis_addr);
      step();
      chk("mis_pulse_end", 32'(fetch_misalign), 32'd0);

      // pc wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); clr_in();
      fetch_one(32'hFFFF_FFFC, 32'h3333_0013, "wrap");
      inst_ready = 1'b1; step(); clr_in();
      chk("wrap_addr", imem_addr, 32'h0);

      // timeout: one pulse after MAX_WAIT idle wait cycles, keeps waiting
      imem_gnt = 1'b1; step(); clr_in();
      chk("to_k0", 32'(fetch_timeout), 32'd0);
      for (int k = 1; k <= MAX_WAIT + 4; k++) begin
         step();
         chk($sformatf("to_k%0d", k), 32'(fetch_timeout), 32'(k == MAX_WAIT));
      end
      chk("to_still_wait", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h4444_0013; step(); clr_in();
      chk("to_late_valid", 32'(inst_valid), 32'd1);
      chk("to_late_inst", inst, 32'h4444_0013);

      // reset during WAIT; response after release is ignored
      inst_ready = 1'b1; step(); clr_in();
      imem_gnt = 1'b1; step(); clr_in();
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_req", 32'(imem_req), 32'd0);
      chk("mrst_inst", inst, NOP);
      chk("mrst_inst_pc", inst_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; step(); clr_in();
      chk("mrst_valid", 32'(inst_valid), 32'd0);
      fetch_one(RESET_PC, 32'h5555_0013, "mrst");

      // randomized traffic against the reference model
      rst_n = 1'b0; clr_in(); step(); rst_n = 1'b1;
      m_started = 0; m_pending = 0; m_stale = 0; m_held = 0; m_to = 0; m_mis = 0;
      m_pc = RESET_PC; m_word = NOP; m_wpc = 0; m_wait = 0;
      for (int c = 0; c < 4000; c++) begin
         logic        flush, slow, mreq, mis;
         logic [32:0] tm;
         int          ev;
         mreq = m_started && !m_pending && !m_held;
         chk("rnd_req", 32'(imem_req), 32'(mreq));
         if (mreq) chk("rnd_addr", imem_addr, m_pc);
         chk("rnd_valid", 32'(inst_valid), 32'(m_held));
         chk("rnd_inst", inst, m_word);
         chk("rnd_inst_pc", inst_pc, m_wpc);
         chk("rnd_timeout", 32'(fetch_timeout), 32'(m_to));
         chk("rnd_misalign", 32'(fetch_misalign), 32'(m_mis));
         if (n_chk - n_pass > 20) begin
            $display("FAIL rnd_abort: %0d failures", n_chk - n_pass);
            break;
         end

         slow = ((c / 500) % 2) == 1;
         ev = $urandom_range(0, 15);
         trap = (ev == 0) || (ev == 4);
         mret = (ev == 1);
         redirect_valid = (ev == 2) || (ev == 3) || (ev == 4);
         redirect_pc = $urandom;
         mepc = $urandom;
         if ($urandom_range(0, 3) != 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) != 0) mepc = mepc & 32'hFFFF_FFFC;
         mtvec = $urandom;
         imem_gnt = mreq && ($urandom_range(0, 2) != 0);
         imem_rvalid = m_pending && (slow ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 0));
         imem_rdata = $urandom;
         inst_ready = ($urandom_range(0, 3) != 0);

         flush = trap || mret || redirect_valid;
         tm = tgt_of(trap, mret, mtvec, mepc, redirect_pc);
         mis = tm[32];
         m_to = m_pending && !imem_rvalid && (m_wait == MAX_WAIT - 1);
         if (m_pending && !imem_rvalid) begin
            if (m_wait < MAX_WAIT) m_wait++;
         end else begin
            m_wait = 0;
         end
         if (!m_started) begin
            m_started = 1;
         end else if (m_pending) begin
            if (imem_rvalid) begin
               m_pending = 0;
               if (!(m_stale || flush)) begin
                  m_held = 1; m_word = imem_rdata; m_wpc = m_pc;
               end
               m_stale = 0;
            end else if (flush) begin
               m_stale = 1;
            end
         end else if (m_held) begin
            if (flush) m_held = 0;
            else if (inst_ready) begin
               m_held = 0; m_pc = m_pc + 32'd4;
            end
         end else if (imem_gnt) begin
            m_pending = 1; m_stale = flush;
         end
         if (flush) m_pc = tm[31:0];
         m_mis = flush && mis;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
